// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - decode input and staged control outputs of pipe_ctrl_unit
interface pipe_ctrl_unit_if #(
    parameter int ILL_CNT_W = 8,
    parameter int IMM_SRC_W = 3
);
    logic [6:0]           i_opcode_d;
    logic                 i_flush_e;
    logic [IMM_SRC_W-1:0] o_imm_src_d;
    logic [1:0]           o_alu_op_e;
    logic                 o_alu_src_e;
    logic                 o_alu_src_a_e;
    logic                 o_jmp_e;
    logic                 o_jalr_e;
    logic                 o_branch_e;
    logic                 o_load_e;
    logic                 o_mem_write_m;
    logic                 o_reg_write_m;
    logic [1:0]           o_result_src_m;
    logic                 o_reg_write_w;
    logic [1:0]           o_result_src_w;
    logic                 o_illegal_e;
    logic [ILL_CNT_W-1:0] o_illegal_cnt;

    modport slave (
        input  i_opcode_d, i_flush_e,
        output o_imm_src_d, o_alu_op_e, o_alu_src_e, o_alu_src_a_e, o_jmp_e, o_jalr_e,
               o_branch_e, o_load_e, o_mem_write_m, o_reg_write_m, o_result_src_m,
               o_reg_write_w, o_result_src_w, o_illegal_e, o_illegal_cnt
    );

    modport master (
        output i_opcode_d, i_flush_e,
        input  o_imm_src_d, o_alu_op_e, o_alu_src_e, o_alu_src_a_e, o_jmp_e, o_jalr_e,
               o_branch_e, o_load_e, o_mem_write_m, o_reg_write_m, o_result_src_m,
               o_reg_write_w, o_result_src_w, o_illegal_e, o_illegal_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - RV32I decode with E/M/W control pipeline; CTRL_ILLEGAL_TRAP_EN enables illegal-opcode tracking
module pipe_ctrl_unit #(
    parameter int ILL_CNT_W = 8,
    parameter int IMM_SRC_W = 3
) (
    input logic              i_clk,
    input logic              i_rst,
    pipe_ctrl_unit_if.slave  io_ctrl
);

    logic                 w_reg_write_d;
    logic [1:0]           w_result_src_d;
    logic                 w_mem_write_d;
    logic                 w_jmp_d;
    logic                 w_jalr_d;
    logic                 w_branch_d;
    logic [1:0]           w_alu_op_d;
    logic                 w_alu_src_d;
    logic                 w_alu_src_a_d;
    logic [IMM_SRC_W-1:0] w_imm_src_d;

    // Unknown opcodes fall through to the all-zero NOP bundle
    always_comb begin
        w_reg_write_d  = 1'b0;
        w_result_src_d = 2'b00;
        w_mem_write_d  = 1'b0;
        w_jmp_d        = 1'b0;
        w_jalr_d       = 1'b0;
        w_branch_d     = 1'b0;
        w_alu_op_d     = 2'b00;
        w_alu_src_d    = 1'b0;
        w_alu_src_a_d  = 1'b0;
        w_imm_src_d    = '0;
        case (io_ctrl.i_opcode_d)
            7'b0110011: begin
                w_reg_write_d = 1'b1;
                w_alu_op_d    = 2'b10;
            end
            7'b0000011: begin
                w_reg_write_d  = 1'b1;
                w_result_src_d = 2'b01;
                w_alu_src_d    = 1'b1;
            end
            7'b0010011: begin
                w_reg_write_d = 1'b1;
                w_alu_op_d    = 2'b10;
                w_alu_src_d   = 1'b1;
            end
            7'b1100111: begin
                w_reg_write_d  = 1'b1;
                w_result_src_d = 2'b10;
                w_jmp_d        = 1'b1;
                w_jalr_d       = 1'b1;
                w_alu_src_d    = 1'b1;
            end
            7'b0100011: begin
                w_mem_write_d = 1'b1;
                w_alu_src_d   = 1'b1;
                w_imm_src_d   = IMM_SRC_W'(3'b001);
            end
            7'b1100011: begin
                w_branch_d  = 1'b1;
                w_alu_op_d  = 2'b01;
                w_imm_src_d = IMM_SRC_W'(3'b010);
            end
            7'b1101111: begin
                w_reg_write_d  = 1'b1;
                w_result_src_d = 2'b10;
                w_jmp_d        = 1'b1;
                w_imm_src_d    = IMM_SRC_W'(3'b011);
            end
            7'b0110111: begin
                w_reg_write_d  = 1'b1;
                w_result_src_d = 2'b11;
                w_alu_src_d    = 1'b1;
                w_imm_src_d    = IMM_SRC_W'(3'b100);
            end
            7'b0010111: begin
                w_reg_write_d = 1'b1;
                w_alu_src_d   = 1'b1;
                w_alu_src_a_d = 1'b1;
                w_imm_src_d   = IMM_SRC_W'(3'b100);
            end
            default: ;
        endcase
    end

    assign io_ctrl.o_imm_src_d = w_imm_src_d;

    logic       r_reg_write_e;
    logic [1:0] r_result_src_e;
    logic       r_mem_write_e;
    logic       r_jmp_e;
    logic       r_jalr_e;
    logic       r_branch_e;
    logic [1:0] r_alu_op_e;
    logic       r_alu_src_e;
    logic       r_alu_src_a_e;
    logic       r_reg_write_m;
    logic [1:0] r_result_src_m;
    logic       r_mem_write_m;
    logic       r_reg_write_w;
    logic [1:0] r_result_src_w;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reg_write_e  <= 1'b0;
            r_result_src_e <= 2'b00;
            r_mem_write_e  <= 1'b0;
            r_jmp_e        <= 1'b0;
            r_jalr_e       <= 1'b0;
            r_branch_e     <= 1'b0;
            r_alu_op_e     <= 2'b00;
            r_alu_src_e    <= 1'b0;
            r_alu_src_a_e  <= 1'b0;
            r_reg_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_mem_write_m  <= 1'b0;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= 2'b00;
        end else begin
            if (io_ctrl.i_flush_e) begin
                r_reg_write_e  <= 1'b0;
                r_result_src_e <= 2'b00;
                r_mem_write_e  <= 1'b0;
                r_jmp_e        <= 1'b0;
                r_jalr_e       <= 1'b0;
                r_branch_e     <= 1'b0;
                r_alu_op_e     <= 2'b00;
                r_alu_src_e    <= 1'b0;
                r_alu_src_a_e  <= 1'b0;
            end else begin
                r_reg_write_e  <= w_reg_write_d;
                r_result_src_e <= w_result_src_d;
                r_mem_write_e  <= w_mem_write_d;
                r_jmp_e        <= w_jmp_d;
                r_jalr_e       <= w_jalr_d;
                r_branch_e     <= w_branch_d;
                r_alu_op_e     <= w_alu_op_d;
                r_alu_src_e    <= w_alu_src_d;
                r_alu_src_a_e  <= w_alu_src_a_d;
            end
            r_reg_write_m  <= r_reg_write_e;
            r_result_src_m <= r_result_src_e;
            r_mem_write_m  <= r_mem_write_e;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
        end
    end

    assign io_ctrl.o_alu_op_e     = r_alu_op_e;
    assign io_ctrl.o_alu_src_e    = r_alu_src_e;
    assign io_ctrl.o_alu_src_a_e  = r_alu_src_a_e;
    assign io_ctrl.o_jmp_e        = r_jmp_e;
    assign io_ctrl.o_jalr_e       = r_jalr_e;
    assign io_ctrl.o_branch_e     = r_branch_e;
    assign io_ctrl.o_load_e       = (r_result_src_e == 2'b01);
    assign io_ctrl.o_mem_write_m  = r_mem_write_m;
    assign io_ctrl.o_reg_write_m  = r_reg_write_m;
    assign io_ctrl.o_result_src_m = r_result_src_m;
    assign io_ctrl.o_reg_write_w  = r_reg_write_w;
    assign io_ctrl.o_result_src_w = r_result_src_w;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                 w_illegal_d;
    logic                 r_illegal_e;
    logic [ILL_CNT_W-1:0] r_illegal_cnt;

    always_comb begin
        w_illegal_d = 1'b1;
        case (io_ctrl.i_opcode_d)
            7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111: w_illegal_d = 1'b0;
            default: w_illegal_d = 1'b1;
        endcase
    end

    // Counter saturates at all-ones so a trap storm never reads back as a small count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_illegal_e   <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_illegal_e <= w_illegal_d & ~io_ctrl.i_flush_e;
            if (w_illegal_d && !io_ctrl.i_flush_e && (r_illegal_cnt != {ILL_CNT_W{1'b1}}))
                r_illegal_cnt <= r_illegal_cnt + ILL_CNT_W'(1);
        end
    end

    assign io_ctrl.o_illegal_e   = r_illegal_e;
    assign io_ctrl.o_illegal_cnt = r_illegal_cnt;
`else
    assign io_ctrl.o_illegal_e   = 1'b0;
    assign io_ctrl.o_illegal_cnt = {ILL_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed and random checks of pipe_ctrl_unit against a table-driven pipeline model
module tb_pipe_ctrl_unit;
    localparam int CW = 2;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       j;
        logic       jr;
        logic       br;
        logic [1:0] aop;
        logic       as;
        logic       asa;
        logic [2:0] imm;
    } ctl_t;

    logic [6:0] ref_ops [9] = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
    ctl_t ref_ctl [9] = '{14'b1_00_0_0_0_0_10_0_0_000, 14'b1_01_0_0_0_0_00_1_0_000,
                          14'b1_00_0_0_0_0_10_1_0_000, 14'b1_10_0_1_1_0_00_1_0_000,
                          14'b0_00_1_0_0_0_00_1_0_001, 14'b0_00_0_0_0_1_01_0_0_010,
                          14'b1_10_0_1_0_0_00_0_0_011, 14'b1_11_0_0_0_0_00_1_0_100,
                          14'b1_00_0_0_0_0_00_1_1_100};

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    ctl_t           exp_e, exp_m, exp_w;
    logic           exp_ill_e;
    logic [CW-1:0]  exp_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.ILL_CNT_W(CW), .IMM_SRC_W(3)) bus ();

    pipe_ctrl_unit #(.ILL_CNT_W(CW), .IMM_SRC_W(3)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .io_ctrl (bus.slave)
    );

    function automatic ctl_t ref_decode(input logic [6:0] op);
        ctl_t r = '0;
        for (int i = 0; i < 9; i++)
            if (op == ref_ops[i]) r = ref_ctl[i];
        return r;
    endfunction

    function automatic logic ref_illegal(input logic [6:0] op);
        logic found = 1'b0;
        for (int i = 0; i < 9; i++)
            if (op == ref_ops[i]) found = 1'b1;
        return !found;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " E"}, 32'({bus.o_alu_op_e, bus.o_alu_src_e, bus.o_alu_src_a_e, bus.o_jmp_e,
                              bus.o_jalr_e, bus.o_branch_e, bus.o_load_e}),
            32'({exp_e.aop, exp_e.as, exp_e.asa, exp_e.j, exp_e.jr, exp_e.br, exp_e.rs == 2'b01}));
        chk({tag, " M"}, 32'({bus.o_mem_write_m, bus.o_reg_write_m, bus.o_result_src_m}),
            32'({exp_m.mw, exp_m.rw, exp_m.rs}));
        chk({tag, " W"}, 32'({bus.o_reg_write_w, bus.o_result_src_w}), 32'({exp_w.rw, exp_w.rs}));
        chk({tag, " ill_e"}, 32'(bus.o_illegal_e), 32'(exp_ill_e));
        chk({tag, " ill_cnt"}, 32'(bus.o_illegal_cnt), 32'(exp_cnt));
    endtask

    task automatic model_reset();
        exp_e = '0;
        exp_m = '0;
        exp_w = '0;
        exp_ill_e = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic step(input string tag, input logic [6:0] op, input logic fl);
        ctl_t d;
        logic ill;
        bus.i_opcode_d = op;
        bus.i_flush_e  = fl;
        d = ref_decode(op);
        ill = TRAP && ref_illegal(op) && !fl;
        #1;
        chk({tag, " imm_d"}, 32'(bus.o_imm_src_d), 32'(d.imm));
        @(posedge clk);
        exp_w = exp_m;
        exp_m = exp_e;
        exp_e = fl ? '0 : d;
        exp_ill_e = ill;
        if (ill && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [6:0] op;
        int         pick;
        rst = 1'b1;
        bus.i_opcode_d = 7'b0010111;
        bus.i_flush_e  = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        chk("reset imm_d", 32'(bus.o_imm_src_d), 32'd4);
        @(posedge clk);
        #1 rst = 1'b0;

        step("lw0", 7'b0000011, 1'b0);
        chk("lw load_e", 32'(bus.o_load_e), 32'd1);
        step("lw1", 7'b0110011, 1'b0);
        chk("lw res_m", 32'({bus.o_result_src_m, bus.o_reg_write_m}), 32'b011);
        step("lw2", 7'b0110011, 1'b0);
        chk("lw res_w", 32'({bus.o_result_src_w, bus.o_reg_write_w}), 32'b011);

        step("flush0", 7'b0100011, 1'b1);
        step("flush1", 7'b0110011, 1'b0);
        chk("flush mw_m", 32'(bus.o_mem_write_m), 32'd0);

        step("auipc", 7'b0010111, 1'b0);
        chk("auipc src_a", 32'(bus.o_alu_src_a_e), 32'd1);
        step("lui", 7'b0110111, 1'b0);
        chk("lui src_a", 32'(bus.o_alu_src_a_e), 32'd0);
        step("al2", 7'b0000000, 1'b0);
        chk("auipc res_w", 32'(bus.o_result_src_w), 32'd0);
        step("al3", 7'b0000000, 1'b0);
        chk("lui res_w", 32'(bus.o_result_src_w), 32'd3);

        for (int i = 0; i < 5; i++) step("ill", 7'b1111111, 1'b0);
        step("ill_fl", 7'b1111111, 1'b1);

        step("jal0", 7'b1101111, 1'b0);
        step("jal1", 7'b0100011, 1'b0);
        chk("jal rw_m", 32'(bus.o_reg_write_m), 32'd1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst rw_m", 32'(bus.o_reg_write_m), 32'd0);
        check_all("arst");
        @(posedge clk);
        #1 rst = 1'b0;
        step("post_rst", 7'b1100111, 1'b0);

        for (int i = 0; i < 300; i++) begin
            pick = int'($urandom_range(0, 11));
            op = (pick < 9) ? ref_ops[pick] : 7'($urandom);
            step("rand", op, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
